// File: rtl/cis_pkg.sv
// Shared types and constants for the CIS line-capture receive path.
package cis_pkg;
  localparam int PIX_W  = 8;
  localparam int WORD_W = 32;
  localparam logic [15:0] HDR_MAGIC = 16'hA55A;

  typedef enum logic [2:0] {IDLE, SKIP, CAPT, FLUSH, DONE} state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/cis_pix_pack.sv
// 4:1 byte packer: first pixel lands in [7:0]; completed or flushed words
// appear on word_o one cycle after the pixel/flush that closed them.
module cis_pix_pack
  import cis_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_i,
  input  logic [PIX_W-1:0]  data_i,
  input  logic              flush_i,
  input  logic              clear_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o,
  output logic [1:0]        count_o
);
  logic [23:0]       buf_q, buf_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              vld_q, vld_d;

  // The partial buffer is zeroed after every emitted word, so a flush
  // naturally carries zero padding in the unused upper bytes.
  always_comb begin
    buf_d  = buf_q;
    cnt_d  = cnt_q;
    word_d = word_q;
    vld_d  = 1'b0;
    if (clear_i) begin
      buf_d = '0;
      cnt_d = '0;
    end else if (flush_i) begin
      if (cnt_q != 2'd0) begin
        word_d = {8'h00, buf_q};
        vld_d  = 1'b1;
      end
      buf_d = '0;
      cnt_d = '0;
    end else if (shift_i) begin
      if (cnt_q == 2'd3) begin
        word_d = {data_i, buf_q};
        vld_d  = 1'b1;
        buf_d  = '0;
        cnt_d  = '0;
      end else begin
        case (cnt_q)
          2'd0:    buf_d[7:0]   = data_i;
          2'd1:    buf_d[15:8]  = data_i;
          default: buf_d[23:16] = data_i;
        endcase
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q  <= '0;
      cnt_q  <= '0;
      word_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      cnt_q  <= cnt_d;
      word_q <= word_d;
      vld_q  <= vld_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = vld_q;
  assign count_o      = cnt_q;
endmodule

// File: rtl/cis_line_capture.sv
// CIS line capture: skips dummy pixels, packs active pixels into FIFO words,
// counts lines and signals frame end. Optional line header: CIS_LINE_HEADER_EN.
module cis_line_capture
  import cis_pkg::*;
#(
  parameter int PIX_PER_LINE    = 5184,
  parameter int SKIP_PIX        = 16,
  parameter int LINES_PER_FRAME = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              triger,
  input  logic              stop_req,
  input  logic              adc_valid,
  input  logic [PIX_W-1:0]  adc_data,
  input  logic              fifo_full,
  output logic              wr_en,
  output logic [WORD_W-1:0] wr_data,
  output logic [15:0]       line_cnt,
  output logic              line_err,
  output logic              overflow,
  output logic              frame_done
);
  localparam logic [15:0] LAST_PIX  = 16'(PIX_PER_LINE - 1);
  localparam logic [15:0] LAST_SKIP = 16'(SKIP_PIX - 1);
  localparam state_t      FIRST_ST  = (SKIP_PIX == 0) ? CAPT : SKIP;

  state_t      state_q;
  logic        fs_q, armed_q, fs_fell_q, stop_q;
  logic [15:0] skip_cnt_q, pix_cnt_q, line_cnt_q, line_cnt_d, line_cnt_inc;
  logic        line_err_q, frame_done_q, overflow_q;

  logic        fs_rise, in_line, trig_ok, last_pix, skip_last, truncate;
  logic        end_frame, go_line;
  logic        pk_shift, pk_flush, pk_clear, pk_vld;
  logic [1:0]  pk_cnt;
  logic [WORD_W-1:0] pk_word, hdr_word;
  logic        hdr_fire, wr_req;

  always_comb begin
    fs_rise      = frame_start & ~fs_q;
    in_line      = (state_q == SKIP) || (state_q == CAPT);
    trig_ok      = triger & frame_start & ~fs_fell_q;
    last_pix     = (state_q == CAPT) && adc_valid && (pix_cnt_q == LAST_PIX);
    skip_last    = (state_q == SKIP) && adc_valid && (skip_cnt_q == LAST_SKIP);
    // A trigger on the closing pixel starts the next line rather than truncating.
    truncate     = in_line & trig_ok & ~last_pix;
    line_cnt_inc = sat_inc16(line_cnt_q);
    end_frame    = stop_req | stop_q | ~frame_start | fs_fell_q |
                   ({16'd0, line_cnt_inc} >= 32'(LINES_PER_FRAME));
    go_line      = ((state_q == IDLE) & triger & frame_start & (armed_q | fs_rise))
                 | (truncate & ((state_q == SKIP) | (pk_cnt == 2'd0)))
                 | (state_q == FLUSH)
                 | (last_pix & ~end_frame & trig_ok);
    if ((state_q == IDLE) && fs_rise)
      line_cnt_d = '0;
    else if (last_pix)
      line_cnt_d = line_cnt_inc;
    else
      line_cnt_d = line_cnt_q;
    pk_shift = (state_q == CAPT) & adc_valid & ~truncate;
    pk_flush = truncate & (state_q == CAPT);
    pk_clear = (state_q == IDLE) | (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      fs_q         <= 1'b0;
      armed_q      <= 1'b0;
      fs_fell_q    <= 1'b0;
      stop_q       <= 1'b0;
      skip_cnt_q   <= '0;
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
      line_err_q   <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      fs_q         <= frame_start;
      line_err_q   <= truncate;
      frame_done_q <= 1'b0;
      line_cnt_q   <= line_cnt_d;
      overflow_q   <= (overflow_q & ~fs_rise) | (wr_req & fifo_full);
      if (fs_rise) armed_q <= 1'b1;
      if (state_q == IDLE) begin
        fs_fell_q <= 1'b0;
        stop_q    <= 1'b0;
      end else if (state_q != DONE) begin
        if (!frame_start) fs_fell_q <= 1'b1;
        if (stop_req)     stop_q    <= 1'b1;
      end
      if (go_line) begin
        state_q    <= FIRST_ST;
        skip_cnt_q <= '0;
        pix_cnt_q  <= '0;
      end else begin
        case (state_q)
          SKIP: begin
            if (skip_last) begin
              state_q   <= CAPT;
              pix_cnt_q <= '0;
            end else if (adc_valid) begin
              skip_cnt_q <= skip_cnt_q + 16'd1;
            end
          end
          CAPT: begin
            if (truncate) begin
              state_q <= FLUSH;
            end else if (last_pix) begin
              if (end_frame) begin
                state_q      <= DONE;
                frame_done_q <= 1'b1;
                armed_q      <= 1'b0;
              end else begin
                state_q <= IDLE;
              end
            end else if (adc_valid) begin
              pix_cnt_q <= pix_cnt_q + 16'd1;
            end
          end
          DONE:    state_q <= IDLE;
          default: ;
        endcase
      end
    end
  end

  cis_pix_pack u_pack (
    .clk          (clk),
    .rst          (rst),
    .shift_i      (pk_shift),
    .data_i       (adc_data),
    .flush_i      (pk_flush),
    .clear_i      (pk_clear),
    .word_o       (pk_word),
    .word_valid_o (pk_vld),
    .count_o      (pk_cnt)
  );

`ifdef CIS_LINE_HEADER_EN
  logic              go_capt, hdr_pend_q;
  logic [WORD_W-1:0] hdr_word_q;

  // Header waits a cycle if the previous line's last word is still leaving.
  assign go_capt  = (go_line & (SKIP_PIX == 0)) | (skip_last & ~truncate);
  assign hdr_fire = hdr_pend_q & ~pk_vld;
  assign hdr_word = hdr_word_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_pend_q <= 1'b0;
      hdr_word_q <= '0;
    end else if (go_capt) begin
      hdr_pend_q <= 1'b1;
      hdr_word_q <= {HDR_MAGIC, line_cnt_d};
    end else if (hdr_fire) begin
      hdr_pend_q <= 1'b0;
    end
  end
`else
  assign hdr_fire = 1'b0;
  assign hdr_word = '0;
`endif

  assign wr_req     = pk_vld | hdr_fire;
  assign wr_en      = wr_req & ~fifo_full;
  assign wr_data    = hdr_fire ? hdr_word : pk_word;
  assign line_cnt   = line_cnt_q;
  assign line_err   = line_err_q;
  assign overflow   = overflow_q;
  assign frame_done = frame_done_q;
endmodule

// File: doc/cis_line_capture.md
Name: cis_line_capture

Overview:
- Receive end of the CIS line-timing interface. The timing generator drives the sensor start pulse, the write trigger and frame_start.
- This block takes the write trigger plus the digitised pixel stream from the AFE/ADC. It discards leading dummy pixels, packs pixels into 32-bit words for the line FIFO, and counts lines.
- Returns line-level status and the frame_done pulse that the timing generator consumes to drop frame_start.

Parameters:
- PIX_PER_LINE, 5184, active pixels captured per line (multiple of 4, max 65532)
- SKIP_PIX, 16, dummy pixels discarded after each trigger
- LINES_PER_FRAME, 4096, lines after which frame_done fires without a stop request

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- frame_start  in  1  capture enable; level from timing generator
- triger  in  1  one-cycle line-write trigger
- stop_req  in  1  level; end frame after current line
- adc_valid  in  1  qualifies adc_data for one cycle
- adc_data  in  8  pixel sample
- fifo_full  in  1  line FIFO full
- wr_en  out  1  FIFO write strobe
- wr_data  out  32  packed pixels; first pixel in [7:0]
- line_cnt  out  16  lines completed this frame
- line_err  out  1  one-cycle pulse on truncated line
- overflow  out  1  sticky; word dropped due to fifo_full
- frame_done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Synchronous reset mid-line discards the partial word with no flush write.
- States: IDLE, SKIP, CAPT, FLUSH, DONE.
  - IDLE: go to SKIP on triger & frame_start. Clear line_cnt on rising edge of frame_start.
  - SKIP: count adc_valid up to SKIP_PIX, then go to CAPT. With SKIP_PIX=0, go straight to CAPT on the trigger.
  - CAPT: each adc_valid shifts adc_data into the packer. At 4 pixels, issue wr_en the next cycle (latency 1). After PIX_PER_LINE pixels: line_cnt++, then to IDLE, or to DONE if stop_req is high or line_cnt reaches LINES_PER_FRAME.
  - DONE: pulse frame_done for 1 cycle, then IDLE. Ignore triger until frame_start falls and rises again.
- triger during SKIP/CAPT:
  - Pulse line_err.
  - If the partial word holds 1-3 pixels, enter FLUSH: write the word zero-padded in the upper bytes, 1 cycle.
  - Then restart SKIP for the new line. line_cnt does not increment.
- frame_start falling mid-line: finish the current line normally, then go to DONE. No new trigger is accepted.
- fifo_full high in the write cycle: drop the word, set overflow, keep counting pixels. overflow clears only on rst or frame_start rising.
- adc_valid in IDLE/DONE: ignored.
- Widths: pixel counter 16 bit. line_cnt 16 bit, saturates at 16'hFFFF.
- triger coincident with the last pixel of a line: the line completes first; the trigger starts the next line and no line_err fires.

Optional Feature:
- Macro: CIS_LINE_HEADER_EN.
- Defined: on entry to CAPT, write one header word before any pixel word, 1 cycle. The header is {16'hA55A, line_cnt}. If fifo_full is high, the header is dropped and overflow is set.
- Undefined: no header; the FIFO carries pixel words only.

Decomposition:
- Package cis_pkg:
  - state enum (IDLE/SKIP/CAPT/FLUSH/DONE)
  - HDR_MAGIC=16'hA55A
  - PIX_W=8, WORD_W=32
- Sub-module cis_pix_pack: 4:1 byte packer.
  - Inputs: shift, data, flush, clear.
  - Outputs: word, word_valid, partial count.
- The FSM and counters stay in the top level.

Test Plan:
- Normal line: SKIP_PIX=16, PIX_PER_LINE=8. Drive triger, then 24 valid pixels 0x00..0x17 → words 0x13121110 and 0x17161514; line_cnt=1; no line_err.
- Stop: stop_req high during line 3 → line 3 completes, line_cnt=3, frame_done pulses 1 cycle, then further triger is ignored.
- Truncation: second triger after 6 active pixels → line_err pulse, flush word 0x00001514, line_cnt unchanged, new line captured correctly.
- Backpressure: fifo_full high during the 2nd word write → that word is missing, overflow=1, remains 1 through the next lines, cleared by frame_start re-rise.
- Reset mid-CAPT: rst for 1 cycle after 3 pixels → no wr_en, all outputs 0, next triger captures a clean line.
- Header (CIS_LINE_HEADER_EN): line 0 → first write is 0xA55A0000, followed by the pixel words.
